// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// sram_pkg : shared types for the SRAM tile reader slice
// Rev 1.0
// ============================================================================
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

    localparam int RD_FIFO_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/sram_tile_reader_if.sv
`default_nettype none
// ============================================================================
// sram_tile_reader_if : control, SRAM read port and output stream of the reader
// Rev 1.0
// ============================================================================
interface sram_tile_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] stride;
    logic [ADDR_WIDTH:0]   len;
    logic                  busy;
    logic                  done;
    logic                  mem_cs;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_dout;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        input  start, base_addr, stride, len, mem_dout, out_ready,
        output busy, done, mem_cs, mem_we, mem_addr, out_valid, out_data, out_last
    );

    modport slave (
        output start, base_addr, stride, len, mem_dout, out_ready,
        input  busy, done, mem_cs, mem_we, mem_addr, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/sram_rd_fifo.sv
`default_nettype none
// ============================================================================
// sram_rd_fifo : 2-entry return-data FIFO (data plus last flag) with count
// Rev 1.0
// ============================================================================
module sram_rd_fifo
    import sram_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] push_data_i,
    input  wire logic             pop_i,
    output logic      [1:0]       count_o,
    output logic      [WIDTH-1:0] head_o
);
    localparam int PTR_W = $clog2(RD_FIFO_DEPTH);

    logic [WIDTH-1:0] mem_q [RD_FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [1:0]       count_q;

    // Storage is cleared on reset so the stream data output reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
endmodule
`default_nettype wire

// File: rtl/sram_tile_reader.sv
`default_nettype none
// ============================================================================
// sram_tile_reader : strided SRAM fetch engine feeding a valid/ready stream
// Rev 1.0
// ============================================================================
module sram_tile_reader
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    sram_tile_reader_if.master  rd_if
);
    localparam int CW = ADDR_WIDTH + 1;

    rd_state_t             state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [CW-1:0]         len_q;
    logic [CW-1:0]         issue_q;
    logic                  rd_pending_q;
    logic                  last_pending_q;
    logic                  busy_q;
    logic                  done_q;

    logic [1:0]            w_count;
    logic [DATA_WIDTH:0]   w_head;
    logic                  w_valid;
    logic                  w_pop;
    logic [2:0]            w_occ;
    logic                  w_cs;
    logic                  w_issue_last;

    assign w_valid      = (w_count != 2'd0);
    assign w_pop        = w_valid & rd_if.out_ready;
    // Occupancy after this cycle's pop; a slot freed by the pop may be reused at once.
    assign w_occ        = {1'b0, w_count} + {2'b0, rd_pending_q} - {2'b0, w_pop};
    assign w_cs         = (state_q == RUN) && (w_occ < 3'd2);
    assign w_issue_last = (issue_q == len_q - CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            stride_q       <= '0;
            len_q          <= '0;
            issue_q        <= '0;
            rd_pending_q   <= 1'b0;
            last_pending_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            rd_pending_q <= w_cs;
            done_q       <= 1'b0;
            if (w_cs) begin
                last_pending_q <= w_issue_last;
            end
            case (state_q)
                IDLE: begin
                    if (rd_if.start) begin
                        addr_q   <= rd_if.base_addr;
                        stride_q <= rd_if.stride;
                        len_q    <= rd_if.len;
                        issue_q  <= '0;
                        if (rd_if.len != '0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_cs) begin
                        addr_q  <= addr_q + stride_q;
                        issue_q <= issue_q + CW'(1);
                        if (w_issue_last) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Leave as the final word is handed over so done follows the last handshake.
                    if (!rd_pending_q && (w_count == 2'd0 || (w_count == 2'd1 && w_pop))) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    sram_rd_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rd_pending_q),
        .push_data_i ({last_pending_q, rd_if.mem_dout}),
        .pop_i       (w_pop),
        .count_o     (w_count),
        .head_o      (w_head)
    );

    assign rd_if.busy      = busy_q;
    assign rd_if.done      = done_q;
    assign rd_if.mem_cs    = w_cs;
    assign rd_if.mem_we    = 1'b0;
    assign rd_if.mem_addr  = addr_q;
    assign rd_if.out_valid = w_valid;
    assign rd_if.out_data  = w_head[DATA_WIDTH-1:0];
    assign rd_if.out_last  = w_head[DATA_WIDTH];
endmodule
`default_nettype wire

// File: tb/tb_sram_tile_reader.sv
`default_nettype none
// ============================================================================
// tb_sram_tile_reader : directed bench for the strided SRAM tile reader
// Rev 1.0
// ============================================================================
module tb_sram_tile_reader;
    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic clk_en = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    sram_tile_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    sram_tile_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .rd_if (bus)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    logic [7:0] sram [16];
    always @(posedge clk) begin
        if (bus.mem_cs && !bus.mem_we) bus.mem_dout <= sram[bus.mem_addr];
    end

    logic [7:0] q_addr [$];
    logic [7:0] q_data [$];
    logic       q_last [$];
    logic       cs_tr    [32];
    logic [3:0] addr_tr  [32];
    logic       valid_tr [32];
    logic [7:0] data_tr  [32];
    logic       last_tr  [32];
    logic       busy_tr  [32];
    int         done_cyc;
    int         valid_seen;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // mode 0: ready always 1; mode 1: ready low in cycles 3..8; mode 2: random ready.
    task automatic run_xfer(input int base, input int stride, input int len, input int mode, input int poke);
        logic       held;
        logic [7:0] held_data;
        held = 1'b0;
        held_data = '0;
        q_addr.delete();
        q_data.delete();
        q_last.delete();
        done_cyc = -1;
        valid_seen = 0;
        for (int i = 0; i < 32; i++) begin
            cs_tr[i] = 0; addr_tr[i] = 0; valid_tr[i] = 0;
            data_tr[i] = 0; last_tr[i] = 0; busy_tr[i] = 0;
        end
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = 4'(base);
        bus.stride    = 4'(stride);
        bus.len       = 5'(len);
        bus.out_ready = 1'b1;
        for (int cyc = 1; cyc < 200; cyc++) begin
            @(posedge clk);
            #1;
            bus.start = (cyc == poke);
            if (cyc == poke) begin
                bus.base_addr = 4'd8;
                bus.len       = 5'd9;
            end
            case (mode)
                1:       bus.out_ready = !(cyc >= 3 && cyc <= 8);
                2:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b1;
            endcase
            @(negedge clk);
            if (cyc < 32) begin
                cs_tr[cyc] = bus.mem_cs;  addr_tr[cyc] = bus.mem_addr;
                valid_tr[cyc] = bus.out_valid; data_tr[cyc] = bus.out_data;
                last_tr[cyc] = bus.out_last;   busy_tr[cyc] = bus.busy;
            end
            if (bus.mem_cs) q_addr.push_back({4'd0, bus.mem_addr});
            if (bus.out_valid) valid_seen++;
            if (held) begin
                check_val("stall_valid", {31'd0, bus.out_valid}, 32'd1);
                check_val("stall_data", {24'd0, bus.out_data}, {24'd0, held_data});
            end
            held = bus.out_valid && !bus.out_ready;
            held_data = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                q_data.push_back(bus.out_data);
                q_last.push_back(bus.out_last);
            end
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
        end
        if (done_cyc < 0) check_val("timeout_done", 32'd0, 32'd1);
        bus.out_ready = 1'b1;
    endtask

    int e_cs    [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
    int e_addr  [8] = '{0, 3, 4, 5, 6, 0, 0, 0};
    int e_valid [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    int e_data  [8] = '{0, 0, 0, 'h13, 'h14, 'h15, 'h16, 0};
    int e_busy  [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    int w_addr  [3] = '{14, 1, 4};
    int w_data  [3] = '{'h1E, 'h11, 'h14};

    initial begin
        for (int i = 0; i < 16; i++) sram[i] = 8'(8'h10 + i);
        bus.mem_dout  = '0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.stride    = '0;
        bus.len       = '0;
        bus.out_ready = 1'b1;

        // 1: asynchronous reset with the clock stopped
        #3 rst = 1'b1;
        #1;
        check_val("rst_busy",     {31'd0, bus.busy},      32'd0);
        check_val("rst_done",     {31'd0, bus.done},      32'd0);
        check_val("rst_cs",       {31'd0, bus.mem_cs},    32'd0);
        check_val("rst_we",       {31'd0, bus.mem_we},    32'd0);
        check_val("rst_addr",     {28'd0, bus.mem_addr},  32'd0);
        check_val("rst_valid",    {31'd0, bus.out_valid}, 32'd0);
        check_val("rst_data",     {24'd0, bus.out_data},  32'd0);
        check_val("rst_last",     {31'd0, bus.out_last},  32'd0);
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_val("idle_cs",   {31'd0, bus.mem_cs}, 32'd0);
            check_val("idle_busy", {31'd0, bus.busy},   32'd0);
        end

        // 2: streaming with ready held high
        run_xfer(3, 1, 4, 0, 0);
        for (int c = 1; c < 8; c++) begin
            check_val($sformatf("s_cs%0d", c), {31'd0, cs_tr[c]}, e_cs[c]);
            if (e_cs[c] != 0) check_val($sformatf("s_addr%0d", c), {28'd0, addr_tr[c]}, e_addr[c]);
            check_val($sformatf("s_valid%0d", c), {31'd0, valid_tr[c]}, e_valid[c]);
            if (e_valid[c] != 0) begin
                check_val($sformatf("s_data%0d", c), {24'd0, data_tr[c]}, e_data[c]);
                check_val($sformatf("s_last%0d", c), {31'd0, last_tr[c]}, (c == 6) ? 32'd1 : 32'd0);
            end
            check_val($sformatf("s_busy%0d", c), {31'd0, busy_tr[c]}, e_busy[c]);
        end
        check_val("s_done_cyc", done_cyc, 32'd7);

        // 3: address wrap-around
        run_xfer(14, 3, 3, 0, 0);
        check_val("w_naddr", q_addr.size(), 32'd3);
        check_val("w_ndata", q_data.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < q_addr.size()) check_val($sformatf("w_addr%0d", i), {24'd0, q_addr[i]}, w_addr[i]);
            if (i < q_data.size()) check_val($sformatf("w_data%0d", i), {24'd0, q_data[i]}, w_data[i]);
        end

        // 4: fixed backpressure window, then random ready against a model
        run_xfer(0, 1, 6, 1, 0);
        check_val("bp_cs1", {31'd0, cs_tr[1]}, 32'd1);
        check_val("bp_cs2", {31'd0, cs_tr[2]}, 32'd1);
        for (int c = 3; c <= 8; c++) check_val($sformatf("bp_cs%0d", c), {31'd0, cs_tr[c]}, 32'd0);
        check_val("bp_cs9", {31'd0, cs_tr[9]}, 32'd1);
        check_val("bp_n", q_data.size(), 32'd6);
        for (int i = 0; i < q_data.size() && i < 6; i++) begin
            check_val($sformatf("bp_data%0d", i), {24'd0, q_data[i]}, 32'h10 + i);
            check_val($sformatf("bp_last%0d", i), {31'd0, q_last[i]}, (i == 5) ? 32'd1 : 32'd0);
        end
        run_xfer(5, 7, 20, 2, 0);
        check_val("rr_n", q_data.size(), 32'd20);
        for (int i = 0; i < q_data.size() && i < 20; i++) begin
            check_val($sformatf("rr_data%0d", i), {24'd0, q_data[i]}, 32'h10 + ((5 + 7 * i) % 16));
            check_val($sformatf("rr_last%0d", i), {31'd0, q_last[i]}, (i == 19) ? 32'd1 : 32'd0);
        end

        // 5: zero length, then a start pulse while running
        run_xfer(3, 1, 0, 0, 0);
        check_val("z_done_cyc", done_cyc, 32'd1);
        check_val("z_ncs", q_addr.size(), 32'd0);
        check_val("z_valid", valid_seen, 32'd0);
        run_xfer(0, 1, 4, 0, 2);
        check_val("ig_n", q_data.size(), 32'd4);
        check_val("ig_done_cyc", done_cyc, 32'd7);

        // 6: reset in the middle of an 8-word transfer
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = 4'd0; bus.stride = 4'd1; bus.len = 5'd8;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        begin
            int n_hs;
            n_hs = 0;
            for (int c = 0; c < 50 && n_hs < 2; c++) begin
                @(negedge clk);
                if (bus.out_valid && bus.out_ready) n_hs++;
            end
            check_val("mr_hs", n_hs, 32'd2);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("mr_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("mr_cs",    {31'd0, bus.mem_cs},    32'd0);
        check_val("mr_busy",  {31'd0, bus.busy},      32'd0);
        check_val("mr_data",  {24'd0, bus.out_data},  32'd0);
        check_val("mr_addr",  {28'd0, bus.mem_addr},  32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_xfer(0, 1, 2, 0, 0);
        check_val("mr_n", q_data.size(), 32'd2);
        for (int i = 0; i < q_data.size() && i < 2; i++) begin
            check_val($sformatf("mr_data%0d", i), {24'd0, q_data[i]}, 32'h10 + i);
            check_val($sformatf("mr_last%0d", i), {31'd0, q_last[i]}, (i == 1) ? 32'd1 : 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sram_tile_reader.md
Name: sram_tile_reader

Overview:
- Read-side initiator for the single-port `sram` block: drives cs/we/addr and consumes dout.
- On `start` it fetches `len` words from `base_addr` with constant `stride`, absorbing the SRAM's 1-cycle read latency.
- Delivers the words in order on a valid/ready stream to the compute datapath (e.g. operand feed for the MAC array).
- Full throughput of 1 word/cycle under continuous ready; lossless under backpressure.

Parameters:
- DATA_WIDTH, 8, word width; must match the attached SRAM.
- ADDR_WIDTH, 4, SRAM address width; the SRAM holds 2**ADDR_WIDTH words.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; accepted only in IDLE.
- base_addr  in  ADDR_WIDTH  first word address; sampled on acceptance.
- stride  in  ADDR_WIDTH  address increment; sampled on acceptance.
- len  in  ADDR_WIDTH+1  word count, 0..2**(ADDR_WIDTH+1)-1; sampled on acceptance.
- busy  out  1  high in RUN/DRAIN.
- done  out  1  one-cycle completion pulse.
- mem_cs  out  1  to SRAM cs.
- mem_we  out  1  to SRAM we; constant 0.
- mem_addr  out  ADDR_WIDTH  to SRAM addr.
- mem_dout  in  DATA_WIDTH  from SRAM dout.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_data  out  DATA_WIDTH  stream data.
- out_last  out  1  high with the final word of a transfer.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - state=IDLE; FIFO emptied; counters and the pending flag cleared.
  - busy, done, mem_cs, mem_we, out_valid, out_last = 0; mem_addr = 0; out_data = 0.
  - Any in-flight read is discarded.
- FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE: start=1 latches base_addr, stride and len. Goes to RUN if len != 0, else to DONE.
  - RUN: issues reads. After the read with issue index len-1, goes to DRAIN.
  - DRAIN: waits until the FIFO is empty and no read is pending, then goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start outside IDLE is ignored.
- Read issue:
  - mem_cs = (state==RUN) && (fifo_count + rd_pending - pop) < 2, where pop = out_valid && out_ready.
  - This is a deliberate combinational path from out_ready to mem_cs.
  - mem_addr = base_addr + issue_idx*stride, modulo 2**ADDR_WIDTH. Implemented as a running adder with natural wrap.
- Read return:
  - rd_pending is registered as mem_cs.
  - When rd_pending=1, mem_dout is written into the 2-entry FIFO on that cycle's edge.
  - The last-flag is tracked per entry.
- Output: out_valid = FIFO non-empty. out_data and out_last come from the FIFO head. Pop on out_valid && out_ready.
- Latency, with start in cycle 0:
  - cycle 1: mem_cs=1, mem_addr=base.
  - cycle 2: rd_pending=1.
  - cycle 3: first out_valid.
  - done pulses the cycle after the last handshake.
  - len=0: done in cycle 1, mem_cs never asserted.
- Data invariants:
  - The FIFO never overflows; total of FIFO occupancy plus pending reads is at most 2.
  - Order is preserved; no word is dropped or duplicated.
  - out_valid and out_data stay stable while out_ready=0.
- Counters are ADDR_WIDTH+1 bits. len > 2**ADDR_WIDTH is legal; addresses wrap and words are re-read.
- Simultaneous FIFO push and pop at count 2 cannot occur. Push and pop at count 1 leaves count 1.

Decomposition:
- Shared package sram_pkg:
  - rd_state_t enum {IDLE, RUN, DRAIN, DONE}.
  - localparam RD_FIFO_DEPTH = 2.
- One sub-module, sram_rd_fifo: 2-entry, DATA_WIDTH+1 wide (data plus last) FIFO with count output.

Test Plan:
1. Reset: assert rst mid-cycle with clk stopped -> all outputs 0 immediately; after release, idle and no mem_cs.
2. Streaming, with SRAM ADDR_WIDTH=4 preloaded mem[i]=0x10+i and out_ready=1:
   - stimulus: start, base=3, stride=1, len=4.
   - response: mem_addr 3,4,5,6 in cycles 1-4; out_data 0x13,0x14,0x15,0x16 in cycles 3-6; out_last only with 0x16; done in cycle 7; busy high in cycles 1-6.
3. Wrap-around: base=14, stride=3, len=3 -> addresses 14,1,4; data 0x1E,0x11,0x14.
4. Backpressure: len=6, out_ready held 0 during cycles 3-8 then 1 -> mem_cs stops once 2 words are held or pending; all 6 words delivered in order; out_data stable while stalled; random-ready variant is checked against a scoreboard.
5. len=0 -> done in cycle 1, mem_cs never 1, out_valid never 1. A start pulse during RUN is ignored: the word count is unchanged.
6. Reset mid-transfer: assert rst after 2 of 8 words are accepted -> outputs 0 at once; a new start with base=0, len=2 yields 0x10,0x11 with nothing stale emitted.
